// File: rtl/vdp99_pkg.sv
// Shared vdp99 definitions: CPU port modes, control-byte layout and VRAM sizing.
package vdp99_pkg;

    localparam int VRAM_SIZE_DEF = 8192;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    localparam int CTRL_REG   = 7;
    localparam int CTRL_WRITE = 6;

    // Which byte of the two-byte address/register sequence arrives next
    typedef enum logic {
        ADDR_LSB = 1'b0,
        ADDR_MSB = 1'b1
    } addr_phase_e;

endpackage

// File: rtl/vdp_vram_ram.sv
// Single-port synchronous VRAM array, read-before-write, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module vdp_vram_ram #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vdp_vram.sv
// CPU-facing VRAM of the vdp99: address-register sequencer, read-ahead latch,
// one-deep CPU op queue and a display DMA read port that always wins the RAM.
module vdp_vram
    import vdp99_pkg::*;
#(
    parameter  int VRAM_SIZE       = VRAM_SIZE_DEF,
    localparam int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_tick,
    input  logic                       wr_tick,
    input  logic                       mode,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    input  logic [VRAM_ADDR_WIDTH-1:0] dma_addr,
    input  logic                       dma_rd_tick,
    output logic [7:0]                 dma_dout
);

    localparam int AW = VRAM_ADDR_WIDTH;

    addr_phase_e  phase_q,     phase_d;
    logic [7:0]   lsb_q,       lsb_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic         wmode_q,     wmode_d;
    logic         pend_q,      pend_d;
    logic         pend_we_q,   pend_we_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]   pend_dat_q,  pend_dat_d;
    logic         cpu_ret_q,   cpu_ret_d;
    logic         dma_ret_q,   dma_ret_d;
    logic [7:0]   latch_q,     latch_d;
    logic [7:0]   dma_hold_q,  dma_hold_d;

    logic          queue_rd;
    logic          queue_wr;
    logic [AW-1:0] queue_addr;
    logic [13:0]   ctrl_addr;
    logic          exec;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_rdata;

    assign ctrl_addr = {din[5:0], lsb_q};
    assign exec      = pend_q & ~dma_rd_tick;
    assign ram_addr  = dma_rd_tick ? dma_addr : pend_addr_q;
    assign ram_we    = exec & pend_we_q;

    always_comb begin
        phase_d     = phase_q;
        lsb_d       = lsb_q;
        addr_d      = addr_q;
        wmode_d     = wmode_q;
        pend_d      = pend_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_dat_d  = pend_dat_q;
        latch_d     = latch_q;
        dma_hold_d  = dma_hold_q;
        queue_rd    = 1'b0;
        queue_wr    = 1'b0;
        queue_addr  = addr_q;

        // rd_tick wins when both strobes arrive in the same cycle
        if (rd_tick) begin
            if (mode == MODE_ADDR) begin
                phase_d = ADDR_LSB;
            end else begin
                queue_rd = 1'b1;
            end
        end else if (wr_tick) begin
            if (mode == MODE_ADDR) begin
                if (phase_q == ADDR_LSB) begin
                    lsb_d   = din;
                    phase_d = ADDR_MSB;
                end else begin
                    phase_d = ADDR_LSB;
                    if (!din[CTRL_REG]) begin
                        queue_addr = AW'(ctrl_addr);
                        addr_d     = queue_addr;
                        wmode_d    = din[CTRL_WRITE];
                        queue_rd   = ~din[CTRL_WRITE];
                    end
                end
            end else begin
                queue_wr = 1'b1;
            end
        end

        // A strobe arriving while an op is still queued loses its memory op
        if ((queue_rd || queue_wr) && !pend_q) begin
            pend_d      = 1'b1;
            pend_we_d   = queue_wr;
            pend_addr_d = queue_addr;
            pend_dat_d  = din;
            addr_d      = queue_addr + AW'(1);
        end

        if (exec) begin
            pend_d = 1'b0;
        end

        if (exec && pend_we_q) begin
            latch_d = pend_dat_q;
        end else if (cpu_ret_q) begin
            latch_d = ram_rdata;
        end

        if (dma_ret_q) begin
            dma_hold_d = ram_rdata;
        end

        cpu_ret_d = exec & ~pend_we_q;
        dma_ret_d = dma_rd_tick;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q     <= ADDR_LSB;
            lsb_q       <= '0;
            addr_q      <= '0;
            wmode_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_dat_q  <= '0;
            cpu_ret_q   <= 1'b0;
            dma_ret_q   <= 1'b0;
            latch_q     <= '0;
            dma_hold_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            lsb_q       <= lsb_d;
            addr_q      <= addr_d;
            wmode_q     <= wmode_d;
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_dat_q  <= pend_dat_d;
            cpu_ret_q   <= cpu_ret_d;
            dma_ret_q   <= dma_ret_d;
            latch_q     <= latch_d;
            dma_hold_q  <= dma_hold_d;
        end
    end

    // DMA data is taken straight off the RAM the cycle after the tick, then held
    assign dma_dout = dma_ret_q ? ram_rdata : dma_hold_q;
    assign dout     = latch_q;

    vdp_vram_ram #(
        .DEPTH (VRAM_SIZE),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (pend_dat_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_vdp_vram.sv
// Directed bench for vdp_vram: fill/readback, wrap, status abort, DMA priority and reset.
module tb_vdp_vram;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_tick;
    logic        wr_tick;
    logic        mode;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [12:0] dma_addr;
    logic        dma_rd_tick;
    logic [7:0]  dma_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vdp_vram dut (
        .clk         (clk),
        .reset       (reset),
        .rd_tick     (rd_tick),
        .wr_tick     (wr_tick),
        .mode        (mode),
        .din         (din),
        .dout        (dout),
        .dma_addr    (dma_addr),
        .dma_rd_tick (dma_rd_tick),
        .dma_dout    (dma_dout)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic m, input logic [7:0] d);
        mode    = m;
        din     = d;
        wr_tick = 1'b1;
        cyc(1);
        wr_tick = 1'b0;
        cyc(2);
    endtask

    task automatic cpu_rd(input logic m, output logic [7:0] q);
        mode    = m;
        rd_tick = 1'b1;
        q       = dout;
        cyc(1);
        rd_tick = 1'b0;
        cyc(2);
    endtask

    initial begin
        logic [7:0] q;

        reset       = 1'b0;
        rd_tick     = 1'b0;
        wr_tick     = 1'b0;
        mode        = 1'b0;
        din         = 8'h00;
        dma_addr    = '0;
        dma_rd_tick = 1'b0;
        cyc(3);
        check_val("rst_dout", {8'h0, dout}, 16'h0000);
        check_val("rst_dma_dout", {8'h0, dma_dout}, 16'h0000);
        reset = 1'b1;
        cyc(2);

        // Fill RAM[0..0x1FFE] with i&0xFF
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b1, 8'h40);
        for (int i = 0; i < 16'h1FFF; i++) begin
            cpu_wr(1'b0, 8'(i));
        end
        check_val("fill_last_latch", {8'h0, dout}, 16'h00FE);

        // Read back the whole array plus one to see the wrap to address 0
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b1, 8'h00);
        for (int i = 0; i < 16'h2000; i++) begin
            cpu_rd(1'b0, q);
            if (i != 16'h1FFF) check_val("seq_rd", {8'h0, q}, 16'(i & 8'hFF));
        end
        cpu_rd(1'b0, q);
        check_val("rd_wrap", {8'h0, q}, 16'h0000);

        // Write wrap: 0x1FFF then 0x0000
        cpu_wr(1'b1, 8'hFF);
        cpu_wr(1'b1, 8'h5F);
        check_val("wmode_no_prefetch", {8'h0, dout}, 16'h0001);
        cpu_wr(1'b0, 8'hAA);
        check_val("wr_latch", {8'h0, dout}, 16'h00AA);
        cpu_wr(1'b0, 8'h55);
        cpu_wr(1'b1, 8'hFF);
        cpu_wr(1'b1, 8'h1F);
        cpu_rd(1'b0, q);
        check_val("wr_wrap_1fff", {8'h0, q}, 16'h00AA);
        cpu_rd(1'b0, q);
        check_val("wr_wrap_0000", {8'h0, q}, 16'h0055);

        // Status read aborts a half-written address
        cpu_wr(1'b1, 8'h99);
        cpu_rd(1'b1, q);
        cpu_wr(1'b1, 8'h11);
        cpu_wr(1'b1, 8'h33);
        cpu_rd(1'b0, q);
        check_val("status_abort_rd0", {8'h0, q}, 16'h0011);
        cpu_rd(1'b0, q);
        check_val("status_abort_rd1", {8'h0, q}, 16'h0012);

        // Back-to-back DMA reads
        dma_addr    = 13'h1100;
        dma_rd_tick = 1'b1;
        @(posedge clk); #1;
        dma_addr = 13'h1101;
        @(negedge clk);
        check_val("dma0", {8'h0, dma_dout}, 16'h0000);
        @(posedge clk); #1;
        dma_addr = 13'h1102;
        @(negedge clk);
        check_val("dma1", {8'h0, dma_dout}, 16'h0001);
        @(posedge clk); #1;
        dma_rd_tick = 1'b0;
        @(negedge clk);
        check_val("dma2", {8'h0, dma_dout}, 16'h0002);
        cyc(3);
        check_val("dma_hold", {8'h0, dma_dout}, 16'h0002);
        check_val("dma_cpu_latch", {8'h0, dout}, 16'h0013);
        cpu_rd(1'b0, q);
        check_val("post_dma_rd", {8'h0, q}, 16'h0013);

        // CPU read queued while DMA owns the RAM
        dma_addr    = 13'h0005;
        dma_rd_tick = 1'b1;
        mode        = 1'b0;
        rd_tick     = 1'b1;
        q           = dout;
        check_val("defer_strobe", {8'h0, q}, 16'h0014);
        cyc(1);
        rd_tick = 1'b0;
        cyc(4);
        check_val("defer_latch", {8'h0, dout}, 16'h0014);
        @(negedge clk);
        check_val("defer_dma", {8'h0, dma_dout}, 16'h0005);
        @(posedge clk); #1;
        dma_rd_tick = 1'b0;
        cyc(3);
        cpu_rd(1'b0, q);
        check_val("defer_rd0", {8'h0, q}, 16'h0015);
        cpu_rd(1'b0, q);
        check_val("defer_rd1", {8'h0, q}, 16'h0016);

        // Register write leaves the address alone
        cpu_wr(1'b1, 8'h10);
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b1, 8'h05);
        cpu_wr(1'b1, 8'h81);
        cpu_rd(1'b0, q);
        check_val("regwr_rd0", {8'h0, q}, 16'h0010);
        cpu_rd(1'b0, q);
        check_val("regwr_rd1", {8'h0, q}, 16'h0011);

        // Reset after an LSB write clears the byte flag
        cpu_wr(1'b1, 8'h34);
        reset = 1'b0;
        #2;
        check_val("midrst_dout", {8'h0, dout}, 16'h0000);
        check_val("midrst_dma", {8'h0, dma_dout}, 16'h0000);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        cpu_wr(1'b1, 8'h22);
        cpu_wr(1'b1, 8'h02);
        cpu_rd(1'b0, q);
        check_val("midrst_lsb", {8'h0, q}, 16'h0022);

        // rd_tick and wr_tick together: the read wins, no write happens
        mode    = 1'b0;
        din     = 8'hEE;
        rd_tick = 1'b1;
        wr_tick = 1'b1;
        q       = dout;
        cyc(1);
        rd_tick = 1'b0;
        wr_tick = 1'b0;
        cyc(2);
        check_val("rdwr_strobe", {8'h0, q}, 16'h0023);
        cpu_rd(1'b0, q);
        check_val("rdwr_next", {8'h0, q}, 16'h0024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_vram.md
Name: vdp_vram

Overview:
- CPU-facing video RAM block of the TMS9918-style VDP (vdp99).
- Holds VRAM_SIZE bytes of single-port synchronous RAM.
- Implements the VDP address-register state machine with auto-increment and a read-ahead latch for CPU data reads/writes.
- Provides a priority DMA read port used by the display fetch engine.

Parameters:
- VRAM_SIZE, 8192, bytes of VRAM; must be a power of two.
- VRAM_ADDR_WIDTH, $clog2(VRAM_SIZE), derived address width; not overridden.

Ports:
- clk  in  1  pixel clock (25 MHz); sole clock.
- reset  in  1  asynchronous, active-low reset.
- rd_tick  in  1  one-cycle CPU read strobe.
- wr_tick  in  1  one-cycle CPU write strobe.
- mode  in  1  0 = data port, 1 = address/status port.
- din  in  8  CPU write data.
- dout  out  8  CPU read data (read-ahead latch).
- dma_addr  in  VRAM_ADDR_WIDTH  display fetch address.
- dma_rd_tick  in  1  display fetch strobe.
- dma_dout  out  8  display fetch data.

Behaviour:
- Reset (async, active-low):
  - addr = 0, first-byte flag (addr_lsb_pending) = 0, write_mode = 0, CPU op pending = 0.
  - Read-ahead latch, dout and dma_dout = 0.
  - RAM contents are not cleared.
- wr_tick with mode=1, flag=0: latch din as address LSB; set flag.
- wr_tick with mode=1, flag=1: clear flag.
  - If din[7]=0: addr = {din[5:0], LSB} truncated to VRAM_ADDR_WIDTH; write_mode = din[6].
  - If write_mode=0: queue a prefetch (read-ahead latch <= RAM[addr]; addr increments).
  - If din[7]=1 (register write): addr and write_mode are unchanged; the value is handled outside this block.
- rd_tick with mode=1 (status read): clears the flag only; addr is unchanged; dout is not driven by this block for status.
- wr_tick with mode=0: queue a write.
  - RAM[addr] <= din; read-ahead latch <= din.
  - addr increments.
  - Write is independent of write_mode, as on the TMS9918.
- rd_tick with mode=0:
  - dout shows the read-ahead latch during the strobe cycle.
  - Then queue a prefetch: latch <= RAM[addr]; addr increments.
  - The first read after setting read address A returns RAM[A].
- Address increment wraps modulo VRAM_SIZE (0x1FFF -> 0x0000).
- RAM arbitration:
  - One access per clock.
  - dma_rd_tick has absolute priority: dma_dout <= RAM[dma_addr], valid the cycle after the tick.
  - A queued CPU op (one-deep pending register) executes on the first cycle with dma_rd_tick=0.
  - Its latch update is visible on dout no later than two cycles after that cycle.
- Back-to-back CPU strobes while an op is still pending are illegal. The later strobe's memory op is dropped and addr is not advanced for it; no other corruption occurs.
- wr_tick and rd_tick asserted together: rd_tick takes precedence; wr_tick is ignored.
- Reset mid-operation aborts any pending op.

Decomposition:
- Shared vdp99 package:
  - MODE_DATA = 0, MODE_ADDR = 1.
  - Control-byte bit positions: CTRL_REG = 7, CTRL_WRITE = 6.
  - Default VRAM_SIZE.
- One sub-module: vdp_vram_ram.
  - Single-port synchronous RAM (addr, we, wdata, rdata), inferable as block RAM.
  - Holds no control logic.

Test Plan:
- Set write address 0x0000 (mode1: 0x00, 0x40), then write bytes i&0xFF for i = 0..0x1FFE with three-cycle spacing -> RAM[i] = i&0xFF; RAM[0x1FFF] is untouched.
- Set read address 0x0000 (0x00, 0x00), then 0x2000 reads -> each dout equals i&0xFF except index 0x1FFF, which is X/unwritten. The address wraps to 0 without error.
- Status-read abort: mode1 wr 0x99, mode1 rd, then mode1 wr 0x11, 0x33 -> addr = 0x1311 in read mode; the next two data reads return RAM[0x1311] and RAM[0x1312].
- DMA: dma_rd_tick on three consecutive cycles with 0x1100, 0x1101, 0x1102 -> dma_dout = 0x00, 0x01, 0x02 on the following cycles; CPU state is unchanged.
- CPU read queued while dma_rd_tick is held -> the op is deferred until DMA idles; dout/addr are correct afterwards; no lost or duplicated increment.
- Assert reset mid-sequence after an LSB write -> flag cleared; the next mode1 byte is treated as an LSB.
